counter_control_unit: RTL and testbench

Command front-end for the up/down counter datapath: turns three raw push-buttons and UART command bytes into the `enable`, `clear` and `mode` controls the datapath consumes. Each button is synchronised, debounced and edge-detected. Button and UART events are merged, and a three-state Moore FSM produces registered control outputs. It sits directly upstream of the counter datapath; its outputs drive that block's `enable`, `clear` and `mode` ports one-to-one.

---
 rtl/counter_control_unit.sv | 150 +++++++++++++++
 tb/tb_counter_control_unit.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/counter_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : counter_control_unit
// Purpose  : Debounced push-button and UART command front-end driving the
//            enable/clear/mode controls of the up/down counter datapath.
// Revision : 1.0 - initial release
// ============================================================================
module counter_control_unit #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_run_stop,
    input  logic       btn_clear,
    input  logic       btn_mode,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       enable,
    output logic       clear,
    output logic       mode,
    output logic [1:0] o_state
);

    localparam int              C_CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [C_CNT_W-1:0] C_CNT_MAX = C_CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_STOP  = 2'b00,
        ST_RUN   = 2'b01,
        ST_CLEAR = 2'b10
    } state_t;

    logic [2:0] w_btn_raw;
    logic [2:0] w_btn_edge;

    assign w_btn_raw = {btn_mode, btn_clear, btn_run_stop};

    // Bit 0 = run_stop, bit 1 = clear, bit 2 = mode
    for (genvar gi = 0; gi < 3; gi++) begin : g_btn
        logic               r_sync1;
        logic               r_sync2;
        logic               r_db;
        logic               r_db_prev;
        logic [C_CNT_W-1:0] r_cnt;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_sync1   <= 1'b0;
                r_sync2   <= 1'b0;
                r_db      <= 1'b0;
                r_db_prev <= 1'b0;
                r_cnt     <= '0;
            end else begin
                r_sync1   <= w_btn_raw[gi];
                r_sync2   <= r_sync1;
                r_db_prev <= r_db;
                if (r_sync2 != r_db) begin
                    if (r_cnt == C_CNT_MAX) begin
                        r_db  <= r_sync2;
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + C_CNT_W'(1);
                    end
                end else begin
                    r_cnt <= '0;
                end
            end
        end

        assign w_btn_edge[gi] = r_db & ~r_db_prev;
    end

    logic w_uart_run;
    logic w_uart_clr;
    logic w_uart_mode;

    always_comb begin
        w_uart_run  = 1'b0;
        w_uart_clr  = 1'b0;
        w_uart_mode = 1'b0;
        if (rx_valid) begin
            case (rx_data)
                8'h52, 8'h72: w_uart_run  = 1'b1;
                8'h43, 8'h63: w_uart_clr  = 1'b1;
                8'h4D, 8'h6D: w_uart_mode = 1'b1;
                default: ;
            endcase
        end
    end

    logic r_evt_run;
    logic r_evt_clr;
    logic r_evt_mode;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_evt_run  <= 1'b0;
            r_evt_clr  <= 1'b0;
            r_evt_mode <= 1'b0;
        end else begin
            r_evt_run  <= w_btn_edge[0] | w_uart_run;
            r_evt_clr  <= w_btn_edge[1] | w_uart_clr;
            r_evt_mode <= w_btn_edge[2] | w_uart_mode;
        end
    end

    state_t w_next;
    state_t r_state;
    logic   r_enable;
    logic   r_clear;
    logic   r_mode;

    // Clear outranks run_stop in STOP; in RUN only run_stop matters.
    always_comb begin
        w_next = ST_STOP;
        case (r_state)
            ST_STOP: begin
                if (r_evt_clr)      w_next = ST_CLEAR;
                else if (r_evt_run) w_next = ST_RUN;
                else                w_next = ST_STOP;
            end
            ST_RUN:   w_next = r_evt_run ? ST_STOP : ST_RUN;
            ST_CLEAR: w_next = ST_STOP;
            default:  w_next = ST_STOP;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_STOP;
            r_enable <= 1'b0;
            r_clear  <= 1'b0;
            r_mode   <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_enable <= (w_next == ST_RUN);
            r_clear  <= (w_next == ST_CLEAR);
            if (r_evt_mode) begin
                r_mode <= ~r_mode;
            end
        end
    end

    assign enable  = r_enable;
    assign clear   = r_clear;
    assign mode    = r_mode;
    assign o_state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_counter_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_counter_control_unit
// Purpose  : Table-driven UART vectors plus directed button/reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_counter_control_unit;

    localparam int D = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_run_stop;
    logic       btn_clear;
    logic       btn_mode;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       enable;
    logic       clear;
    logic       mode;
    logic [1:0] o_state;

    int checks = 0;
    int errors = 0;

    counter_control_unit #(.DEBOUNCE_CYCLES(D)) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_run_stop (btn_run_stop),
        .btn_clear    (btn_clear),
        .btn_mode     (btn_mode),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .enable       (enable),
        .clear        (clear),
        .mode         (mode),
        .o_state      (o_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic [4:0] exp;   // {enable, clear, mode, state[1:0]}
    } vec_t;

    vec_t tbl [25];

    function automatic vec_t mk(input logic v, input logic [7:0] d, input logic [4:0] exp);
        vec_t r;
        r.v   = v;
        r.d   = d;
        r.exp = exp;
        return r;
    endfunction

    task automatic chk(input string name, input logic [4:0] exp);
        logic [4:0] act;
        act = {enable, clear, mode, o_state};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual={en,cl,m,st}=%b required=%b", name, act, exp);
        end
    endtask

    task automatic run_edges(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    localparam logic [4:0] S0_M0 = 5'b00000;
    localparam logic [4:0] R_M0  = 5'b10001;
    localparam logic [4:0] C_M0  = 5'b01010;
    localparam logic [4:0] S0_M1 = 5'b00100;
    localparam logic [4:0] R_M1  = 5'b10101;
    localparam logic [4:0] C_M1  = 5'b01110;

    initial begin
        logic [2:0] bad;

        // Each row's expectation reflects the command of the previous row.
        tbl[0]  = mk(1'b1, 8'h72, S0_M0);
        tbl[1]  = mk(1'b0, 8'h00, R_M0);
        tbl[2]  = mk(1'b1, 8'h43, R_M0);
        tbl[3]  = mk(1'b0, 8'h00, R_M0);
        tbl[4]  = mk(1'b1, 8'h52, R_M0);
        tbl[5]  = mk(1'b0, 8'h00, S0_M0);
        tbl[6]  = mk(1'b1, 8'h63, S0_M0);
        tbl[7]  = mk(1'b0, 8'h00, C_M0);
        tbl[8]  = mk(1'b0, 8'h00, S0_M0);
        tbl[9]  = mk(1'b1, 8'h41, S0_M0);
        tbl[10] = mk(1'b0, 8'h00, S0_M0);
        tbl[11] = mk(1'b1, 8'h6D, S0_M0);
        tbl[12] = mk(1'b1, 8'h72, S0_M1);
        tbl[13] = mk(1'b1, 8'h4D, R_M1);
        tbl[14] = mk(1'b1, 8'h52, R_M0);
        tbl[15] = mk(1'b1, 8'h63, S0_M0);
        tbl[16] = mk(1'b1, 8'h6D, C_M0);
        tbl[17] = mk(1'b0, 8'h00, S0_M1);
        tbl[18] = mk(1'b1, 8'h63, S0_M1);
        tbl[19] = mk(1'b0, 8'h00, C_M1);
        tbl[20] = mk(1'b0, 8'h00, S0_M1);
        tbl[21] = mk(1'b1, 8'h63, S0_M1);
        tbl[22] = mk(1'b1, 8'h72, C_M1);
        tbl[23] = mk(1'b0, 8'h00, S0_M1);
        tbl[24] = mk(1'b0, 8'h00, S0_M1);

        rst          = 1'b1;
        btn_run_stop = 1'b0;
        btn_clear    = 1'b0;
        btn_mode     = 1'b0;
        rx_data      = 8'h00;
        rx_valid     = 1'b0;
        run_edges(3);
        chk("reset_state", S0_M0);
        rst = 1'b0;

        for (int i = 0; i < 25; i++) begin
            rx_valid = tbl[i].v;
            rx_data  = tbl[i].d;
            run_edges(1);
            chk($sformatf("uart_vec%0d", i), tbl[i].exp);
        end
        rx_valid = 1'b0;
        rx_data  = 8'h00;

        // Held button: enable rises D+3 edges after first sample, once only
        btn_run_stop = 1'b1;
        run_edges(D + 3);
        chk("btn_run_edge10", S0_M1);
        run_edges(1);
        chk("btn_run_edge11", R_M1);
        run_edges(8);
        chk("btn_run_held", R_M1);
        btn_run_stop = 1'b0;
        run_edges(15);
        chk("btn_run_release", R_M1);
        btn_run_stop = 1'b1;
        run_edges(D + 3);
        chk("btn_stop_edge10", R_M1);
        run_edges(1);
        chk("btn_stop_edge11", S0_M1);
        run_edges(5);
        btn_run_stop = 1'b0;
        run_edges(15);

        // Bounce: 5 high, 2 low, 7 high never reaches D stable samples
        bad = 3'b000;
        for (int c = 0; c < 34; c++) begin
            btn_clear = (c < 5) || (c >= 7 && c < 14);
            run_edges(1);
            bad = bad | {clear, o_state};
        end
        btn_clear = 1'b0;
        checks++;
        if (bad !== 3'b000) begin
            errors++;
            $display("FAIL bounce_reject actual={cl,st}=%b required=000", bad);
        end

        // Button run edge and UART clear registered in the same cycle
        btn_run_stop = 1'b1;
        run_edges(D + 2);
        rx_valid = 1'b1;
        rx_data  = 8'h63;
        run_edges(1);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        chk("simul_evt", S0_M1);
        run_edges(1);
        chk("simul_clear", C_M1);
        run_edges(1);
        chk("simul_stop", S0_M1);
        run_edges(3);
        chk("simul_no_run", S0_M1);
        btn_run_stop = 1'b0;
        run_edges(15);

        // Asynchronous reset while running with mode=1
        rx_valid = 1'b1;
        rx_data  = 8'h52;
        run_edges(1);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        run_edges(1);
        chk("pre_reset_run", R_M1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset", S0_M0);

        // Button held through reset release gives one delayed press
        btn_run_stop = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        run_edges(D + 3);
        chk("held_thru_rst_edge10", S0_M0);
        run_edges(1);
        chk("held_thru_rst_edge11", R_M0);
        run_edges(10);
        chk("held_thru_rst_once", R_M0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
